spi_controller: RTL
===================

SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 SHALL have parameter: HALF_PERIOD, default 4, system-clock cycles per SCLK half period; legal range 2..255.
REQ-002 SHALL have port: clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  request one write frame; sampled only in IDLE.
REQ-005 SHALL have port: addr  input  7  register address for the frame.
REQ-006 SHALL have port: data  input  8  register write data for the frame.
REQ-007 SHALL have port: cs  output  1  SPI chip select, active-low.
REQ-008 SHALL have port: sclk  output  1  SPI serial clock, mode 0 (idle low).
REQ-009 SHALL have port: copi  output  1  SPI serial data, controller to peripheral.
REQ-010 SHALL have port: busy  output  1  high from frame acceptance until frame completion.
REQ-011 SHALL have port: done  output  1  one-cycle pulse marking frame completion.

Function
REQ-012 SHALL implement states IDLE, SETUP, SHIFT, HOLD and GAP.
REQ-013 SHALL send a 16-bit frame MSB first, laid out as follows:
- bit15 = 1 (write);
- bits14:8 = addr;
- bits7:0 = data.
REQ-014 SHALL, in IDLE with start=1 at a clk edge, latch the frame into a shift register and enter SETUP.
- On that same edge: cs=0, copi=bit15, busy=1.
REQ-015 SHALL keep addr/data changes after acceptance from affecting the frame in flight.
REQ-016 SHALL hold SETUP for HALF_PERIOD cycles with sclk=0, then enter SHIFT.
REQ-017 SHALL, in SHIFT, generate exactly 16 sclk pulses, each HALF_PERIOD cycles high then HALF_PERIOD cycles low.
REQ-018 SHALL change copi only on the edge where sclk falls, advancing to the next bit.
- copi is stable for the whole high phase of each sclk pulse.
REQ-019 SHALL, after the 16th sclk falling edge, enter HOLD: cs=0, sclk=0 for HALF_PERIOD cycles.
REQ-020 SHALL, on leaving HOLD, set cs=1 and copi=0, then enter GAP for HALF_PERIOD cycles.
REQ-021 SHALL, on leaving GAP, return to IDLE with busy=0 and done=1 for exactly that one cycle.
REQ-022 SHALL keep busy high for exactly 35*HALF_PERIOD cycles per frame (140 at default).
REQ-023 SHALL ignore start whenever busy=1; no queuing.
REQ-024 SHALL, with start held high continuously, begin the next frame one cycle after done.
- Minimum cs-high time between frames = HALF_PERIOD+1 cycles.
REQ-025 SHALL, when idle, drive cs=1, sclk=0, copi=0.
REQ-026 SHALL use an internal cycle divider of ceil(log2(HALF_PERIOD+1)) bits and a 5-bit bit counter, neither of which wraps mid-frame.

Reset
REQ-027 SHALL, on rst=0 at any time including mid-frame, immediately force the following without waiting for clk:
- state=IDLE;
- cs=1, sclk=0, copi=0;
- busy=0, done=0;
- all counters and the shift register cleared.
REQ-028 SHALL resume normal operation on the first clk edge after rst deasserts; start seen on that edge is accepted.
REQ-029 SHALL NOT produce a done pulse for a frame aborted by reset.

Verification
REQ-030 Single write, addr=0x04, data=0xAA, HALF_PERIOD=4 -> copi sampled at 16 sclk rises = 1,0000100,10101010; busy high 140 cycles; one done pulse.
REQ-031 Loopback into the team's SPI peripheral, writes to addr 0x00..0x04 with data 0x11,0x22,0x33,0x44,0x80 -> the peripheral's five registers hold those values.
REQ-032 start pulsed at cycles 10 and 50 after an accepted start -> exactly one frame; no second cs fall until start is reasserted after done.
REQ-033 start held high for 3 frames -> 3 done pulses 141 cycles apart; cs high for 5 cycles between frames.
REQ-034 rst asserted after the 7th sclk rise -> cs=1, sclk=0, busy=0 immediately; no done; next start yields a complete, correct frame.
REQ-035 HALF_PERIOD=2, addr=0x7F, data=0xFF -> copi all ones across 16 rises; sclk high/low 2 cycles each; busy high 70 cycles.

Source files
------------

// File: rtl/spi_controller.sv
// SPI mode-0 write controller: one 16-bit frame {1, addr, data}, MSB first, per accepted start.
// Latency: busy for 35*HALF_PERIOD cycles per frame; start is ignored while busy, with no queuing.
module spi_controller #(
  parameter int HALF_PERIOD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [7:0] data,
  output logic       cs,
  output logic       sclk,
  output logic       copi,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(HALF_PERIOD + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF_PERIOD - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [4:0]    bit_cnt;
  logic [15:0]   shreg;
  logic          cnt_end;

  assign cnt_end = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      cs      <= 1'b1;
      sclk    <= 1'b0;
      copi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= {1'b1, addr, data};
            copi    <= 1'b1;
            cs      <= 1'b0;
            busy    <= 1'b1;
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_end) begin
            cnt   <= '0;
            sclk  <= 1'b1;
            state <= SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          // The low phase of the 16th pulse runs its full length before HOLD starts.
          if (cnt_end) begin
            cnt <= '0;
            if (sclk) begin
              sclk    <= 1'b0;
              shreg   <= {shreg[14:0], 1'b0};
              copi    <= shreg[14];
              bit_cnt <= bit_cnt + 1'b1;
            end else if (bit_cnt == 5'd16) begin
              state <= HOLD;
            end else begin
              sclk <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (cnt_end) begin
            cnt   <= '0;
            cs    <= 1'b1;
            copi  <= 1'b0;
            state <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt_end) begin
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
